// File: rtl/axis_csum_pkg.sv
// Shared types and checksum arithmetic for the AXI-Stream checksum inserter.
// AXIS_CSUM_ONES_COMP_EN selects 32-bit ones'-complement addition instead of modulo 2^32.
package axis_csum_pkg;

   typedef enum logic {
      PASS = 1'b0,
      CSUM = 1'b1
   } state_t;

   localparam int CSUM_W = 32;
   localparam logic [3:0] CSUM_KEEP = 4'hF;

   function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] a,
                                                  input logic [CSUM_W-1:0] b);
      logic [CSUM_W:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef AXIS_CSUM_ONES_COMP_EN
      // End-around carry cannot overflow a second time (max 0xFFFFFFFE + 1).
      return s[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, s[CSUM_W]};
`else
      return s[CSUM_W-1:0];
`endif
   endfunction

endpackage

// File: rtl/axis_csum_word_sum.sv
// Combinational keep-masking and 32-bit word reduction of one beat.
// Additions follow csum_add, so AXIS_CSUM_ONES_COMP_EN applies here too.
module axis_csum_word_sum
   import axis_csum_pkg::*;
#(
   parameter int DATA_W = 512
) (
   input  logic [DATA_W-1:0]   data,
   input  logic [DATA_W/8-1:0] keep,
   output logic [CSUM_W-1:0]   sum
);

   localparam int WORDS = DATA_W / 32;

   logic [DATA_W-1:0] masked;

   always_comb begin
      masked = '0;
      for (int b = 0; b < DATA_W / 8; b++) begin
         masked[b*8 +: 8] = keep[b] ? data[b*8 +: 8] : 8'h00;
      end
   end

   always_comb begin
      sum = '0;
      for (int w = 0; w < WORDS; w++) begin
         sum = csum_add(sum, masked[w*32 +: 32]);
      end
   end

endmodule

// File: rtl/axis_csum_inserter.sv
// Forwards AXI-Stream beats and appends a checksum beat after each group or packet end.
// AXIS_CSUM_ONES_COMP_EN: ones'-complement accumulation with an inverted emitted sum.
module axis_csum_inserter
   import axis_csum_pkg::*;
#(
   parameter int DATA_W      = 512,
   parameter int ID_W        = 6,
   parameter int GROUP_BEATS = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [DATA_W-1:0]   inp_data,
   input  logic                inp_valid,
   output logic                inp_ready,
   input  logic [DATA_W/8-1:0] inp_keep,
   input  logic [ID_W-1:0]     inp_id,
   input  logic                inp_last,
   output logic [DATA_W-1:0]   out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W/8-1:0] out_keep,
   output logic [ID_W-1:0]     out_id,
   output logic                out_last
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(GROUP_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP_BEATS - 1);

   // Valid/ready: a beat moves on a port in any cycle where valid and ready are both high;
   // once raised, out_valid and all output fields hold until out_ready accepts the beat.
   state_t            state;
   logic [CSUM_W-1:0] acc;
   logic [CSUM_W-1:0] beat_sum;
   logic [CSUM_W-1:0] next_sum;
   logic [CSUM_W-1:0] lat_sum;
   logic [CNT_W-1:0]  cnt;
   logic [ID_W-1:0]   lat_id;
   logic              lat_last;
   logic              out_free;
   logic              accept;
   logic              closing;

   axis_csum_word_sum #(.DATA_W(DATA_W)) u_word_sum (
      .data (inp_data),
      .keep (inp_keep),
      .sum  (beat_sum)
   );

   assign next_sum  = csum_add(acc, beat_sum);
   assign out_free  = !out_valid || out_ready;
   assign inp_ready = (state == PASS) && out_free;
   assign accept    = inp_valid && inp_ready;
   assign closing   = inp_last || (cnt == LAST_CNT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= PASS;
         acc       <= '0;
         cnt       <= '0;
         lat_sum   <= '0;
         lat_id    <= '0;
         lat_last  <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         out_keep  <= '0;
         out_id    <= '0;
         out_last  <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            PASS: begin
               if (accept) begin
                  out       <= inp_data;
                  out_keep  <= inp_keep;
                  out_id    <= inp_id;
                  out_last  <= 1'b0;
                  out_valid <= 1'b1;
                  acc       <= next_sum;
                  cnt       <= cnt + CNT_W'(1);
                  if (closing) begin
`ifdef AXIS_CSUM_ONES_COMP_EN
                     lat_sum <= ~next_sum;
`else
                     lat_sum <= next_sum;
`endif
                     lat_id   <= inp_id;
                     lat_last <= inp_last;
                     state    <= CSUM;
                  end
               end
            end
            CSUM: begin
               if (out_free) begin
                  out       <= DATA_W'(lat_sum);
                  out_keep  <= KEEP_W'(CSUM_KEEP);
                  out_id    <= lat_id;
                  out_last  <= lat_last;
                  out_valid <= 1'b1;
                  acc       <= '0;
                  cnt       <= '0;
                  state     <= PASS;
               end
            end
            default: state <= PASS;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_csum_inserter.sv
// Self-checking bench for axis_csum_inserter (default build and with AXIS_CSUM_ONES_COMP_EN).
// A group-level reference model predicts every output beat; monitors compare on the falling edge.
module tb_axis_csum_inserter;

   localparam int DW  = 512;
   localparam int KW  = DW / 8;
   localparam int IW  = 6;
   localparam int GB  = 4;
   localparam int DW2 = 64;
   localparam int KW2 = DW2 / 8;

   logic          clock = 1'b0;
   logic          reset;
   logic [DW-1:0] inp_data;
   logic          inp_valid;
   logic          inp_ready;
   logic [KW-1:0] inp_keep;
   logic [IW-1:0] inp_id;
   logic          inp_last;
   logic [DW-1:0] out;
   logic          out_valid;
   logic          out_ready;
   logic [KW-1:0] out_keep;
   logic [IW-1:0] out_id;
   logic          out_last;

   logic [DW2-1:0] g_data;
   logic           g_valid;
   logic           g_ready;
   logic [KW2-1:0] g_keep;
   logic [IW-1:0]  g_id;
   logic           g_last;
   logic [DW2-1:0] g_out;
   logic           g_out_valid;
   logic           g_out_ready;
   logic [KW2-1:0] g_out_keep;
   logic [IW-1:0]  g_out_id;
   logic           g_out_last;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] exp_data_q[$];
   logic [KW-1:0] exp_keep_q[$];
   logic [IW-1:0] exp_id_q[$];
   logic          exp_last_q[$];
   logic [DW2-1:0] exp2_data_q[$];
   logic [KW2-1:0] exp2_keep_q[$];
   logic [IW-1:0]  exp2_id_q[$];
   logic           exp2_last_q[$];

   logic [63:0] m_total;
   int          m_cnt;
   logic        rand_en;

   axis_csum_inserter #(.DATA_W(DW), .ID_W(IW), .GROUP_BEATS(GB)) dut (
      .clock(clock), .reset(reset),
      .inp_data(inp_data), .inp_valid(inp_valid), .inp_ready(inp_ready),
      .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
      .out(out), .out_valid(out_valid), .out_ready(out_ready),
      .out_keep(out_keep), .out_id(out_id), .out_last(out_last)
   );

   axis_csum_inserter #(.DATA_W(DW2), .ID_W(IW), .GROUP_BEATS(1)) dut_g1 (
      .clock(clock), .reset(reset),
      .inp_data(g_data), .inp_valid(g_valid), .inp_ready(g_ready),
      .inp_keep(g_keep), .inp_id(g_id), .inp_last(g_last),
      .out(g_out), .out_valid(g_out_valid), .out_ready(g_out_ready),
      .out_keep(g_out_keep), .out_id(g_out_id), .out_last(g_out_last)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $fatal(1, "FAIL global_timeout");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Plain sum of all keep-masked little-endian 32-bit words, no wrapping.
   function automatic logic [63:0] masked_total(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                                input int nbytes);
      logic [63:0] t;
      logic [31:0] w;
      t = 64'd0;
      for (int i = 0; i < nbytes / 4; i++) begin
         w = 32'd0;
         for (int j = 0; j < 4; j++) begin
            if (k[i*4+j]) w[j*8 +: 8] = d[(i*4+j)*8 +: 8];
         end
         t = t + 64'(w);
      end
      return t;
   endfunction

   function automatic logic [31:0] fold(input logic [63:0] t);
`ifdef AXIS_CSUM_ONES_COMP_EN
      logic [63:0] f;
      f = t;
      while (f[63:32] != 32'd0) f = {32'd0, f[31:0]} + {32'd0, f[63:32]};
      return ~f[31:0];
`else
      return t[31:0];
`endif
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [KW-1:0] rand_keep();
      logic [KW-1:0] k;
      for (int i = 0; i < KW / 32; i++) k[i*32 +: 32] = $urandom;
      return k;
   endfunction

   task automatic model_push(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic [IW-1:0] id, input logic last);
      exp_data_q.push_back(d);
      exp_keep_q.push_back(k);
      exp_id_q.push_back(id);
      exp_last_q.push_back(1'b0);
      m_total = m_total + masked_total(d, k, KW);
      m_cnt++;
      if (last || m_cnt == GB) begin
         exp_data_q.push_back(DW'(fold(m_total)));
         exp_keep_q.push_back(KW'(4'hF));
         exp_id_q.push_back(id);
         exp_last_q.push_back(last);
         m_total = 64'd0;
         m_cnt   = 0;
      end
   endtask

   task automatic model2_push(input logic [DW2-1:0] d, input logic [KW2-1:0] k,
                              input logic [IW-1:0] id, input logic last);
      exp2_data_q.push_back(d);
      exp2_keep_q.push_back(k);
      exp2_id_q.push_back(id);
      exp2_last_q.push_back(1'b0);
      exp2_data_q.push_back(DW2'(fold(masked_total(DW'(d), KW'(k), KW2))));
      exp2_keep_q.push_back(KW2'(4'hF));
      exp2_id_q.push_back(id);
      exp2_last_q.push_back(last);
   endtask

   // Starts and returns just after a rising edge; records the beat in the model once accepted.
   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic [IW-1:0] id, input logic last, input int gap);
      logic hs;
      int   n;
      repeat (gap) begin
         inp_valid = 1'b0;
         if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clock); #1;
      end
      inp_data  = d;
      inp_keep  = k;
      inp_id    = id;
      inp_last  = last;
      inp_valid = 1'b1;
      n  = 0;
      hs = 1'b0;
      do begin
         if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
         hs = inp_ready;
         @(posedge clock); #1;
         n++;
      end while (!hs && n < 200);
      if (!hs) chk("send_timeout", 0, 1);
      else model_push(d, k, id, last);
      inp_valid = 1'b0;
   endtask

   logic [DW-1:0] e_d;
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_data_q.size() == 0) begin
            chk("extra_beat", 1, 0);
         end else begin
            e_d = exp_data_q.pop_front();
            chk("out_data", out, e_d);
            chk("out_keep", DW'(out_keep), DW'(exp_keep_q.pop_front()));
            chk("out_id", DW'(out_id), DW'(exp_id_q.pop_front()));
            chk("out_last", DW'(out_last), DW'(exp_last_q.pop_front()));
         end
      end
   end

   logic [DW2-1:0] e2_d;
   always @(negedge clock) begin
      if (!reset && g_out_valid && g_out_ready) begin
         if (exp2_data_q.size() == 0) begin
            chk("g1_extra_beat", 1, 0);
         end else begin
            e2_d = exp2_data_q.pop_front();
            chk("g1_out_data", DW'(g_out), DW'(e2_d));
            chk("g1_out_keep", DW'(g_out_keep), DW'(exp2_keep_q.pop_front()));
            chk("g1_out_id", DW'(g_out_id), DW'(exp2_id_q.pop_front()));
            chk("g1_out_last", DW'(g_out_last), DW'(exp2_last_q.pop_front()));
         end
      end
   end

   logic [DW-1:0] s_data;
   logic [KW-1:0] s_keep;
   logic [IW-1:0] s_id;
   logic          s_last;
   logic [DW-1:0] d_tmp;
   logic [31:0]   t1_exp;
   logic          r_last;

   initial begin
      reset = 1'b1;
      inp_data = '0; inp_valid = 1'b0; inp_keep = '0; inp_id = '0; inp_last = 1'b0;
      out_ready = 1'b1;
      g_data = '0; g_valid = 1'b0; g_keep = '0; g_id = '0; g_last = 1'b0;
      g_out_ready = 1'b1;
      m_total = 64'd0; m_cnt = 0; rand_en = 1'b0;

      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_out_valid", DW'(out_valid), 0);
      chk("rst_out", out, 0);
      chk("rst_out_keep", DW'(out_keep), 0);
      chk("rst_out_id", DW'(out_id), 0);
      chk("rst_out_last", DW'(out_last), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_inp_ready", DW'(inp_ready), 1);
      @(posedge clock); #1;

      // Four beats of word0=1, id 3: checksum 4 and a single ready bubble
      d_tmp = DW'(1);
      for (int i = 0; i < 4; i++) send_beat(d_tmp, '1, IW'(3), 1'b0, 0);
      @(negedge clock);
      chk("t1_ready_bubble", DW'(inp_ready), 0);
      @(negedge clock);
      chk("t1_ready_back", DW'(inp_ready), 1);
`ifdef AXIS_CSUM_ONES_COMP_EN
      t1_exp = ~32'd4;
`else
      t1_exp = 32'd4;
`endif
      chk("t1_csum", DW'(out[31:0]), DW'(t1_exp));
      @(posedge clock); #1;

      // Two beats of 0xFFFFFFFF closed by last
      d_tmp = DW'(32'hFFFF_FFFF);
      send_beat(d_tmp, '1, IW'(5), 1'b0, 0);
      send_beat(d_tmp, '1, IW'(5), 1'b1, 0);

      // Single all-0xFF beat with only byte 0 kept
      d_tmp = '1;
      send_beat(d_tmp, KW'(1), IW'(7), 1'b1, 0);

      // Output stall for 5 cycles mid-group
      send_beat(rand_data(), rand_keep(), IW'(9), 1'b0, 0);
      out_ready = 1'b0;
      s_data = out; s_keep = out_keep; s_id = out_id; s_last = out_last;
      d_tmp = rand_data();
      inp_data = d_tmp; inp_keep = '1; inp_id = IW'(9); inp_last = 1'b0; inp_valid = 1'b1;
      repeat (5) begin
         @(negedge clock);
         chk("stall_valid", DW'(out_valid), 1);
         chk("stall_data", out, s_data);
         chk("stall_keep", DW'(out_keep), DW'(s_keep));
         chk("stall_id", DW'(out_id), DW'(s_id));
         chk("stall_last", DW'(out_last), DW'(s_last));
         chk("stall_inp_ready", DW'(inp_ready), 0);
      end
      @(posedge clock); #1;
      out_ready = 1'b1;
      send_beat(d_tmp, '1, IW'(9), 1'b0, 0);
      send_beat(rand_data(), rand_keep(), IW'(9), 1'b0, 0);
      send_beat(rand_data(), rand_keep(), IW'(9), 1'b0, 0);

      // Reset after 2 of 4 beats discards the partial group
      send_beat(rand_data(), '1, IW'(11), 1'b0, 0);
      send_beat(rand_data(), '1, IW'(11), 1'b0, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      chk("mid_rst_out_valid", DW'(out_valid), 0);
      chk("mid_rst_out", out, 0);
      chk("mid_rst_out_keep", DW'(out_keep), 0);
      chk("mid_rst_out_id", DW'(out_id), 0);
      chk("mid_rst_out_last", DW'(out_last), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      m_total = 64'd0;
      m_cnt   = 0;
      chk("mid_rst_queue_empty", DW'(exp_data_q.size()), 0);
      for (int i = 0; i < 4; i++) send_beat(rand_data(), rand_keep(), IW'(12), 1'b0, 0);

      // Random beats, packet ends, idle gaps and sink back-pressure
      rand_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         r_last = (i == 29) || ($urandom_range(0, 5) == 0);
         send_beat(rand_data(), rand_keep(), IW'($urandom_range(0, 63)), r_last,
                   $urandom_range(0, 2));
      end
      rand_en   = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
         @(posedge clock); #1;
      end

      // GROUP_BEATS=1, 64-bit: checksum after every beat at 50% input duty
      for (int k = 0; k < 8; k++) begin
         g_data  = {$urandom, $urandom};
         g_keep  = KW2'($urandom_range(0, 255));
         g_id    = IW'($urandom_range(0, 63));
         g_last  = ($urandom_range(0, 1) != 0);
         g_valid = 1'b1;
         @(negedge clock);
         chk("g1_inp_ready", DW'(g_ready), 1);
         model2_push(g_data, g_keep, g_id, g_last);
         @(posedge clock); #1;
         g_valid = 1'b0;
         @(negedge clock);
         chk("g1_out_valid", DW'(g_out_valid), 1);
         @(posedge clock); #1;
      end
      repeat (3) begin
         @(posedge clock); #1;
      end

      chk("final_queue_empty", DW'(exp_data_q.size()), 0);
      chk("g1_final_queue_empty", DW'(exp2_data_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
